alu_result_stage: RTL and testbench

- Downstream stage of the 32-bit combinational ALU.
- Captures each ALU result with its instruction context into a small FIFO and resolves BEQ/BNE into a branch decision and target.
- Produces write-back data and register-write enable.
- Tracks overflow events: sticky flag plus saturating counter.
- Decouples ALU timing from write-back through a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_result_stage_if.sv | 48 ++++
 rtl/alu_result_fifo.sv | 72 +++++++
 rtl/alu_result_stage.sv | 100 ++++++++++
 tb/tb_alu_result_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the
// result-stage entry format.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Kept as plain constants rather than an enum so that unlisted 4-bit
  // opcodes can still flow through the datapath unchanged.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;

  // One queued instruction outcome, computed when the entry is accepted.
  typedef struct packed {
    logic              trap;
    logic              taken;
    logic              wb_en;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] target;
  } entry_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Only signed add/subtract can raise an overflow event.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU side, the write-back consumer and the result stage.
// master = environment (ALU producer + write-back consumer), slave = stage.
interface alu_result_stage_if #(
  parameter int CNT_W = 8
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_alu_ctrl;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_overflow;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_imm;

  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic [REG_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_wb_data;
  logic              out_branch_taken;
  logic [DATA_W-1:0] out_branch_target;
  logic              out_trap;

  logic              flush;
  logic              clear_ovf;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  ovf_count;

  modport master (
    output in_valid, in_alu_ctrl, in_result, in_zero, in_overflow,
           in_rd, in_pc, in_imm, out_ready, flush, clear_ovf,
    input  in_ready, out_valid, out_wb_en, out_rd, out_wb_data,
           out_branch_taken, out_branch_target, out_trap,
           ovf_sticky, ovf_count
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_result, in_zero, in_overflow,
           in_rd, in_pc, in_imm, out_ready, flush, clear_ovf,
    output in_ready, out_valid, out_wb_en, out_rd, out_wb_data,
           out_branch_taken, out_branch_target, out_trap,
           ovf_sticky, ovf_count
  );

endinterface

// File: rtl/alu_result_fifo.sv
// Generic DEPTH-entry synchronous FIFO with occupancy count and flush.
// Pointers wrap naturally; the extra count bit separates full from empty.
// Head data is read combinationally so a new entry shows one cycle after push.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = mem[rd_ptr];

  // Storage write; a push during flush is discarded.
  // NOTE: the array is reset so the payload outputs read as zero straight
  // out of reset; for deep FIFOs drop this and qualify the data by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: queues ALU results with their context, resolves
// BEQ/BNE into a decision and target, forms write-back controls and tracks
// overflow events (sticky flag + saturating counter).
// Optional build macro ALU_RESULT_OVF_TRAP_EN: an overflowing ADD/SUB is
// marked as a trap and its register write is suppressed.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  entry_t           new_entry;
  entry_t           head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             ovf_event;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  assign accept    = bus.in_valid && !fifo_full;
  assign ovf_event = accept && is_arith(bus.in_alu_ctrl) && bus.in_overflow;

  // Build the entry stored at accept time.
  // NOTE: the whole struct gets a default first so no field can infer a latch.
  always_comb begin
    new_entry         = '0;
    new_entry.taken   = is_branch(bus.in_alu_ctrl) && bus.in_result[0];
    new_entry.target  = bus.in_pc + bus.in_imm;
    new_entry.wb_en   = !is_branch(bus.in_alu_ctrl) && (bus.in_rd != '0);
    new_entry.rd      = bus.in_rd;
    new_entry.wb_data = bus.in_result;
`ifdef ALU_RESULT_OVF_TRAP_EN
    if (is_arith(bus.in_alu_ctrl) && bus.in_overflow) begin
      new_entry.trap  = 1'b1;
      new_entry.wb_en = 1'b0;
    end
`endif
  end

  alu_result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (bus.out_ready),
    .flush (bus.flush),
    .din   (new_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow tracking; an event in the clearing cycle survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.clear_ovf) begin
      sticky_q <= ovf_event;
      cnt_q    <= ovf_event ? CNT_W'(1) : '0;
    end else if (ovf_event) begin
      sticky_q <= 1'b1;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready          = !fifo_full;
  assign bus.out_valid         = !fifo_empty;
  assign bus.out_wb_en         = head.wb_en;
  assign bus.out_rd            = head.rd;
  assign bus.out_wb_data       = head.wb_data;
  assign bus.out_branch_taken  = head.taken;
  assign bus.out_branch_target = head.target;
`ifdef ALU_RESULT_OVF_TRAP_EN
  assign bus.out_trap          = head.trap;
`else
  assign bus.out_trap          = 1'b0;
`endif
  assign bus.ovf_sticky        = sticky_q;
  assign bus.ovf_count         = cnt_q;

  // The FIFO's full flag must agree with its occupancy count.
  a_full_matches_count: assert property (
    @(posedge clk) disable iff (rst) fifo_full == (fifo_count == CW'(DEPTH))
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.CNT_W(CNT_W)) bus();

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  entry_t           mq[$];
  logic             m_sticky = 1'b0;
  logic [CNT_W-1:0] m_cnt    = '0;

  function automatic entry_t model_entry(input logic [3:0] op, input logic [31:0] res,
                                         input logic ovf, input logic [4:0] rd,
                                         input logic [31:0] pc, input logic [31:0] imm);
    entry_t e;
    bit br = (op == OP_BEQ) || (op == OP_BNE);
    bit ev = ((op == OP_ADD) || (op == OP_SUB)) && ovf;
    e.trap    = 1'b0;
    e.taken   = br && res[0];
    e.target  = pc + imm;
    e.wb_en   = !br && (rd != 0);
    e.rd      = rd;
    e.wb_data = res;
`ifdef ALU_RESULT_OVF_TRAP_EN
    if (ev) begin
      e.trap  = 1'b1;
      e.wb_en = 1'b0;
    end
`else
    if (ev) e.trap = 1'b0;
`endif
    return e;
  endfunction

  // Reference model, evaluated on the same edge as the DUT from stable inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = '0;
    end else begin
      bit acc, pop, ev;
      acc = bus.in_valid && (mq.size() < DEPTH);
      pop = bus.out_ready && (mq.size() > 0);
      ev  = acc && ((bus.in_alu_ctrl == OP_ADD) || (bus.in_alu_ctrl == OP_SUB)) && bus.in_overflow;
      if (bus.clear_ovf) begin
        m_sticky = ev;
        m_cnt    = ev ? 1 : 0;
      end else if (ev) begin
        m_sticky = 1'b1;
        if (int'(m_cnt) < (2 ** CNT_W) - 1) m_cnt = m_cnt + 1;
      end
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(model_entry(bus.in_alu_ctrl, bus.in_result, bus.in_overflow,
                                          bus.in_rd, bus.in_pc, bus.in_imm));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.flush       = 1'b0;
    bus.clear_ovf   = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic ovf,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.in_alu_ctrl = op;
    bus.in_result   = res;
    bus.in_zero     = (res == 0);
    bus.in_overflow = ovf;
    bus.in_rd       = rd;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
  endtask

  task automatic test_reset();
    idle();
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.ovf_sticky, bus.ovf_count} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected %b", {bus.out_valid, bus.in_ready, bus.ovf_sticky, bus.ovf_count}, {1'b0, 1'b1, 1'b0, 8'd0});
    end
    n_cmp++;
    if ({bus.out_wb_en, bus.out_rd, bus.out_wb_data, bus.out_branch_taken, bus.out_branch_target, bus.out_trap} !== 72'd0) begin
      n_bad++;
      $display("FAIL reset_payload: got %h expected 0", {bus.out_wb_en, bus.out_rd, bus.out_wb_data, bus.out_branch_taken, bus.out_branch_target, bus.out_trap});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(OP_ADD, 32'd8, 1'b0, 5'd3, 32'h40, 32'h0);
    cycle();
    idle();
    n_cmp++;
    if ({bus.out_valid, bus.out_wb_en, bus.out_rd, bus.out_wb_data, bus.out_branch_taken} !== {1'b1, 1'b1, 5'd3, 32'd8, 1'b0}) begin
      n_bad++;
      $display("FAIL add: got %h expected %h", {bus.out_valid, bus.out_wb_en, bus.out_rd, bus.out_wb_data, bus.out_branch_taken}, {1'b1, 1'b1, 5'd3, 32'd8, 1'b0});
    end
    cycle();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_branch();
    bus.out_ready = 1'b1;
    drive(OP_BEQ, 32'd1, 1'b0, 5'd7, 32'h100, 32'hFFFF_FFF0);
    cycle();
    drive(OP_BNE, 32'd0, 1'b0, 5'd9, 32'h200, 32'h8);
    n_cmp++;
    if ({bus.out_valid, bus.out_branch_taken, bus.out_branch_target, bus.out_wb_en} !== {1'b1, 1'b1, 32'hF0, 1'b0}) begin
      n_bad++;
      $display("FAIL beq: got %h expected %h", {bus.out_valid, bus.out_branch_taken, bus.out_branch_target, bus.out_wb_en}, {1'b1, 1'b1, 32'hF0, 1'b0});
    end
    cycle();
    idle();
    n_cmp++;
    if ({bus.out_valid, bus.out_branch_taken, bus.out_branch_target, bus.out_wb_en} !== {1'b1, 1'b0, 32'h208, 1'b0}) begin
      n_bad++;
      $display("FAIL bne: got %h expected %h", {bus.out_valid, bus.out_branch_taken, bus.out_branch_target, bus.out_wb_en}, {1'b1, 1'b0, 32'h208, 1'b0});
    end
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_heads [3] = '{32'd1, 32'd2, 32'd3};
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 1'b0, 5'd1, 32'h0, 32'h0);
    cycle();
    drive(OP_ADD, 32'd2, 1'b0, 5'd1, 32'h0, 32'h0);
    cycle();
    drive(OP_ADD, 32'd3, 1'b0, 5'd1, 32'h0, 32'h0);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_full: in_ready,out_valid got %b expected 01", {bus.in_ready, bus.out_valid});
    end
    cycle();
    n_cmp++;
    if ({bus.in_ready, bus.out_wb_data} !== {1'b0, exp_heads[0]}) begin
      n_bad++;
      $display("FAIL bp_held: got %h expected %h", {bus.in_ready, bus.out_wb_data}, {1'b0, exp_heads[0]});
    end
    bus.out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (bus.out_wb_data !== exp_heads[1]) begin
      n_bad++;
      $display("FAIL bp_order2: got %0d expected %0d", bus.out_wb_data, exp_heads[1]);
    end
    cycle();
    idle();
    n_cmp++;
    if ({bus.out_valid, bus.out_wb_data} !== {1'b1, exp_heads[2]}) begin
      n_bad++;
      $display("FAIL bp_order3: got %h expected %h", {bus.out_valid, bus.out_wb_data}, {1'b1, exp_heads[2]});
    end
    cycle();
  endtask

  task automatic test_overflow();
    logic exp_trap, exp_wb;
`ifdef ALU_RESULT_OVF_TRAP_EN
    exp_trap = 1'b1; exp_wb = 1'b0;
`else
    exp_trap = 1'b0; exp_wb = 1'b1;
`endif
    idle();
    bus.clear_ovf = 1'b1;
    cycle();
    bus.clear_ovf = 1'b0;
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'hDCBB_23EF, 1'b1, 5'd5, 32'h0, 32'h0);
    cycle();
    idle();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count, bus.out_wb_data} !== {1'b1, 8'd1, 32'hDCBB_23EF}) begin
      n_bad++;
      $display("FAIL ovf_add: got %h expected %h", {bus.ovf_sticky, bus.ovf_count, bus.out_wb_data}, {1'b1, 8'd1, 32'hDCBB_23EF});
    end
    n_cmp++;
    if ({bus.out_trap, bus.out_wb_en} !== {exp_trap, exp_wb}) begin
      n_bad++;
      $display("FAIL ovf_trap: trap,wb_en got %b expected %b", {bus.out_trap, bus.out_wb_en}, {exp_trap, exp_wb});
    end
    bus.out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_clear_ovf();
    bus.out_ready = 1'b1;
    drive(OP_SUB, 32'h8000_0000, 1'b1, 5'd2, 32'h0, 32'h0);
    cycle();
    n_cmp++;
    if (bus.ovf_count !== 8'd2) begin
      n_bad++;
      $display("FAIL ovf_second: count got %0d expected 2", bus.ovf_count);
    end
    bus.clear_ovf = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL clear_vs_event: got %h expected %h", {bus.ovf_sticky, bus.ovf_count}, {1'b1, 8'd1});
    end
    bus.clear_ovf = 1'b1;
    cycle();
    drive(OP_AND, 32'h5, 1'b1, 5'd2, 32'h0, 32'h0);
    bus.clear_ovf = 1'b0;
    cycle();
    idle();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count} !== 9'd0) begin
      n_bad++;
      $display("FAIL clear_and_nonarith: got %h expected 0", {bus.ovf_sticky, bus.ovf_count});
    end
    cycle();
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(OP_ADD, 32'(i), 1'b1, 5'd4, 32'h0, 32'h0);
      cycle();
    end
    idle();
    n_cmp++;
    if ({bus.ovf_sticky, bus.ovf_count} !== {1'b1, 8'd255}) begin
      n_bad++;
      $display("FAIL saturate: got %h expected %h", {bus.ovf_sticky, bus.ovf_count}, {1'b1, 8'd255});
    end
    bus.clear_ovf = 1'b1;
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'd11, 1'b0, 5'd1, 32'h0, 32'h0);
    cycle();
    drive(OP_ADD, 32'd12, 1'b0, 5'd1, 32'h0, 32'h0);
    cycle();
    drive(OP_ADD, 32'd13, 1'b0, 5'd1, 32'h0, 32'h0);
    bus.flush = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_full: out_valid,in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    end
    drive(OP_ADD, 32'd21, 1'b0, 5'd1, 32'h0, 32'h0);
    cycle();
    drive(OP_SUB, 32'd22, 1'b1, 5'd1, 32'h0, 32'h0);
    bus.flush = 1'b1;
    cycle();
    idle();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.ovf_sticky, bus.ovf_count} !== {1'b0, 1'b1, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL flush_accept: got %h expected %h", {bus.out_valid, bus.in_ready, bus.ovf_sticky, bus.ovf_count}, {1'b0, 1'b1, 1'b1, 8'd1});
    end
    cycle();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'hABCD, 1'b1, 5'd6, 32'h10, 32'h20);
    cycle();
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.out_wb_data, bus.out_branch_target, bus.ovf_sticky, bus.ovf_count} !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", {bus.out_valid, bus.in_ready, bus.out_wb_data, bus.out_branch_target, bus.ovf_sticky, bus.ovf_count}, {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 8'd0});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ops [10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_BEQ, OP_BNE, 4'hF};
    entry_t obs;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 9)],
            $urandom(), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()), $urandom(), $urandom());
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.clear_ovf = ($urandom_range(0, 24) == 0);
      cycle();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== {mq.size() != 0, mq.size() < DEPTH}) begin
        n_bad++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, {bus.out_valid, bus.in_ready}, {mq.size() != 0, mq.size() < DEPTH});
      end
      n_cmp++;
      if ({bus.ovf_sticky, bus.ovf_count} !== {m_sticky, m_cnt}) begin
        n_bad++;
        $display("FAIL rand_ovf[%0d]: got %h expected %h", i, {bus.ovf_sticky, bus.ovf_count}, {m_sticky, m_cnt});
      end
      if (mq.size() != 0) begin
        obs.trap    = bus.out_trap;
        obs.taken   = bus.out_branch_taken;
        obs.wb_en   = bus.out_wb_en;
        obs.rd      = bus.out_rd;
        obs.wb_data = bus.out_wb_data;
        obs.target  = bus.out_branch_target;
        n_cmp++;
        if (obs !== mq[0]) begin
          n_bad++;
          $display("FAIL rand_head[%0d]: got %h expected %h", i, obs, mq[0]);
        end
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_add();
    test_branch();
    test_backpressure();
    test_overflow();
    test_clear_ovf();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
